// File: rtl/arrow_input.sv
// Arrow-button front end: sync, debounce and edge-detect four buttons, then queue up to two turns for the game.
// Latency: raw change to press_pulse = 2 + DEBOUNCE_CYCLES + 1 cycles; press_pulse to dir/queue_count = 1 cycle.
// Backpressure: none; a request arriving while the turn queue is full (and no step pops it) is dropped.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   arrow_up/arrow_down   raw active-low buttons (asynchronous)
//   arrow_left/right      raw active-high buttons (asynchronous)
//   step                  one-cycle move tick from the game; consumes one direction
//   dir                   direction for the next move (0 up, 1 down, 2 left, 3 right)
//   press_pulse           one-cycle debounced press strobes {right,left,down,up}
//   queue_count           turn-queue occupancy, 0..2
//
// Build option: define REVERSE_LOCK_EN to drop requests that reverse the tail direction.
module arrow_input #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrow_up,
  input  logic       arrow_down,
  input  logic       arrow_left,
  input  logic       arrow_right,
  input  logic       step,
  output logic [1:0] dir,
  output logic [3:0] press_pulse,
  output logic [1:0] queue_count
);

  // Idle raw levels, {right,left,down,up}: up/down idle high, left/right idle low.
  localparam logic [3:0]       RELEASED = 4'b0011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       synced;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       stable_prev_q, stable_prev_d;
  logic [3:0]       press_q, press_d;

  logic [1:0]       cur_dir_q, cur_dir_d;
  logic [1:0]       q0_q, q0_d;        // queue head
  logic [1:0]       q1_q, q1_d;        // second entry
  logic [1:0]       count_q, count_d;

  logic             req_vld;
  logic [1:0]       req_dir;
  logic [1:0]       tail;
  logic             req_ok;
  logic             push;
  logic             pop;

  assign raw    = {arrow_right, arrow_left, arrow_down, arrow_up};
  // XOR with the idle level so every button reads pressed = 1.
  assign synced = sync2_q ^ RELEASED;

  // Synchroniser, debounce and press edge detect.
  always_comb begin
    sync1_d       = raw;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = '0;
      if (synced[k] != stable_q[k]) begin
        // The cycle that would make the count reach DEBOUNCE_CYCLES accepts the new level.
        if (cnt_q[k] == CNT_LAST) begin
          stable_d[k] = synced[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
    stable_prev_d = stable_q;
    press_d       = stable_q & ~stable_prev_q;
  end

  // Turn queue.
  always_comb begin
    req_vld = |press_q;
    req_dir = 2'd0;
    if (press_q[0]) begin
      req_dir = 2'd0;
    end else if (press_q[1]) begin
      req_dir = 2'd1;
    end else if (press_q[2]) begin
      req_dir = 2'd2;
    end else begin
      req_dir = 2'd3;
    end

    // Requests are checked against the newest pending direction, before any pop this cycle.
    if (count_q == 2'd2) begin
      tail = q1_q;
    end else if (count_q == 2'd1) begin
      tail = q0_q;
    end else begin
      tail = cur_dir_q;
    end

`ifdef REVERSE_LOCK_EN
    // Directions pair up as {0,1} and {2,3}, so flipping bit 0 gives the opposite.
    req_ok = req_vld && (req_dir != tail) && (req_dir != (tail ^ 2'd1));
`else
    req_ok = req_vld && (req_dir != tail);
`endif

    pop  = step && (count_q != 2'd0);
    // A full queue only takes a new entry when a step frees the head in the same cycle.
    push = req_ok && ((count_q != 2'd2) || pop);

    cur_dir_d = step ? dir : cur_dir_q;
    q0_d      = q0_q;
    q1_d      = q1_q;
    count_d   = count_q;
    case ({pop, push})
      2'b10: begin
        q0_d    = q1_q;
        count_d = count_q - 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd0) begin
          q0_d = req_dir;
        end else begin
          q1_d = req_dir;
        end
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          q0_d = req_dir;
        end else begin
          q0_d = q1_q;
          q1_d = req_dir;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= RELEASED;
      sync2_q       <= RELEASED;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      cur_dir_q     <= 2'd0;
      q0_q          <= 2'd0;
      q1_q          <= 2'd0;
      count_q       <= 2'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      press_q       <= press_d;
      cur_dir_q     <= cur_dir_d;
      q0_q          <= q0_d;
      q1_q          <= q1_d;
      count_q       <= count_d;
    end
  end

  assign dir         = (count_q != 2'd0) ? q0_q : cur_dir_q;
  assign press_pulse = press_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_arrow_input.sv
module tb_arrow_input;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic [3:0] pressed = 4'b0000;   // {right,left,down,up}, 1 = pressed
  logic       arrow_up, arrow_down, arrow_left, arrow_right;
  logic [1:0] dir;
  logic [3:0] press_pulse;
  logic [1:0] queue_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign arrow_up    = ~pressed[0];
  assign arrow_down  = ~pressed[1];
  assign arrow_left  =  pressed[2];
  assign arrow_right =  pressed[3];

  always #5 clk = ~clk;

  arrow_input #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (rst),
    .arrow_up    (arrow_up),
    .arrow_down  (arrow_down),
    .arrow_left  (arrow_left),
    .arrow_right (arrow_right),
    .step        (step),
    .dir         (dir),
    .press_pulse (press_pulse),
    .queue_count (queue_count)
  );

  // ---------------- reference model ----------------
  // Synchroniser as a 2-deep history of pressed levels; debounce as a run length of
  // consecutive disagreeing cycles; turn queue as a plain SV queue.
  logic [3:0] m_line [$] = '{4'b0000, 4'b0000};
  logic [3:0] m_stable = 4'b0000;
  logic [3:0] m_prev   = 4'b0000;
  logic [3:0] m_pulse  = 4'b0000;
  int         m_run [4] = '{0, 0, 0, 0};
  int         m_cur = 0;
  int         m_q [$];
  int         m_req, m_tail;
  bit         m_have, m_ok;
  logic [3:0] m_synced, m_now;

  function automatic int m_dir();
    return (m_q.size() != 0) ? m_q[0] : m_cur;
  endfunction

  always @(posedge clk) begin
    m_now = {arrow_right, arrow_left, ~arrow_down, ~arrow_up};
    if (rst) begin
      m_line = '{4'b0000, 4'b0000};
      m_stable = 4'b0000;
      m_prev   = 4'b0000;
      m_pulse  = 4'b0000;
      m_run    = '{0, 0, 0, 0};
      m_cur    = 0;
      m_q.delete();
    end else begin
      m_have = 1'b0;
      m_req  = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_pulse[k] && !m_have) begin
          m_have = 1'b1;
          m_req  = k;
        end
      end
      m_tail = (m_q.size() != 0) ? m_q[m_q.size()-1] : m_cur;
      m_ok   = m_have && (m_req != m_tail);
`ifdef REVERSE_LOCK_EN
      if (m_req == (m_tail ^ 1)) m_ok = 1'b0;
`endif
      if (step) begin
        m_cur = m_dir();
        if (m_q.size() != 0) void'(m_q.pop_front());
      end
      if (m_ok && m_q.size() < 2) m_q.push_back(m_req);

      m_pulse = m_stable & ~m_prev;
      m_prev  = m_stable;

      m_synced = m_line[0];
      for (int k = 0; k < 4; k++) begin
        if (m_synced[k] != m_stable[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_stable[k] = m_synced[k];
            m_run[k]    = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      void'(m_line.pop_front());
      m_line.push_back(m_now);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    step    = 1'b0;
    pressed = 4'b0000;
    tick(2);
    rst = 1'b0;
  endtask

  // Hold a press long enough to qualify, then release and let the release settle.
  task automatic press_wait(input logic [3:0] p);
    pressed = p;
    tick(8);
    pressed = 4'b0000;
    tick(12);
  endtask

  task automatic do_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [3:0] press;
    logic [3:0] exp_pulse;
    logic [1:0] exp_cnt;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vecs [8];
  int   hold [4] = '{0, 0, 0, 0};

  initial begin
    vecs[0] = '{"up",        4'b0001, 4'b0001, 2'd0, 2'd0};
`ifdef REVERSE_LOCK_EN
    vecs[1] = '{"down",      4'b0010, 4'b0010, 2'd0, 2'd0};
    vecs[5] = '{"down_rt",   4'b1010, 4'b1010, 2'd0, 2'd0};
`else
    vecs[1] = '{"down",      4'b0010, 4'b0010, 2'd1, 2'd1};
    vecs[5] = '{"down_rt",   4'b1010, 4'b1010, 2'd1, 2'd1};
`endif
    vecs[2] = '{"left",      4'b0100, 4'b0100, 2'd1, 2'd2};
    vecs[3] = '{"right",     4'b1000, 4'b1000, 2'd1, 2'd3};
    vecs[4] = '{"up_left",   4'b0101, 4'b0101, 2'd0, 2'd0};
    vecs[6] = '{"left_rt",   4'b1100, 4'b1100, 2'd1, 2'd2};
    vecs[7] = '{"all",       4'b1111, 4'b1111, 2'd0, 2'd0};

    // 1: reset state
    do_reset();
    chk("reset_dir",   32'(dir),         0);
    chk("reset_count", 32'(queue_count), 0);
    chk("reset_pulse", 32'(press_pulse), 0);

    // Single and simultaneous presses from reset: exact pulse latency, priority, reverse lock.
    foreach (vecs[i]) begin
      do_reset();
      pressed = vecs[i].press;
      tick(D + 2);
      chk({vecs[i].name, "_early"}, 32'(press_pulse), 0);
      tick(1);
      chk({vecs[i].name, "_pulse"}, 32'(press_pulse), 32'(vecs[i].exp_pulse));
      tick(1);
      chk({vecs[i].name, "_pulse_end"}, 32'(press_pulse), 0);
      chk({vecs[i].name, "_count"}, 32'(queue_count), 32'(vecs[i].exp_cnt));
      chk({vecs[i].name, "_dir"},   32'(dir),         32'(vecs[i].exp_dir));
      pressed = 4'b0000;
      tick(12);
    end

    // 2: glitch of D-1 cycles is ignored; exactly D cycles qualifies
    do_reset();
    pressed = 4'b0100;
    tick(D - 1);
    pressed = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("glitch_pulse", 32'(press_pulse), 0);
    end
    chk("glitch_count", 32'(queue_count), 0);
    pressed = 4'b0100;
    tick(D);
    pressed = 4'b0000;
    tick(2);
    chk("min_press_early", 32'(press_pulse), 0);
    tick(1);
    chk("min_press_pulse", 32'(press_pulse), 'b0100);
    tick(1);
    chk("min_press_count", 32'(queue_count), 1);
    chk("min_press_dir",   32'(dir),         2);
    tick(12);

    // 4: queue fill, drop when full, then drain
    do_reset();
    press_wait(4'b0100);
    press_wait(4'b0010);
    chk("fill_count2", 32'(queue_count), 2);
    chk("fill_dir2",   32'(dir),         2);
    press_wait(4'b1000);
    chk("full_drop_count", 32'(queue_count), 2);
    chk("full_drop_dir",   32'(dir),         2);
    do_step();
    chk("drain1_dir",   32'(dir),         1);
    chk("drain1_count", 32'(queue_count), 1);
    do_step();
    chk("drain2_dir",   32'(dir),         1);
    chk("drain2_count", 32'(queue_count), 0);
    do_step();
    chk("empty_step_dir", 32'(dir), 1);

    // 5: push and pop in the same cycle at full occupancy
    do_reset();
    press_wait(4'b0100);
    press_wait(4'b0010);
    pressed = 4'b1000;
    tick(D + 3);
    chk("simul_pulse", 32'(press_pulse), 'b1000);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    pressed = 4'b0000;
    chk("simul_count", 32'(queue_count), 2);
    chk("simul_dir",   32'(dir),         1);
    do_step();
    chk("simul_next_dir",   32'(dir),         3);
    chk("simul_next_count", 32'(queue_count), 1);
    do_step();
    chk("simul_last_dir",   32'(dir),         3);
    chk("simul_last_count", 32'(queue_count), 0);
    tick(12);

    // 6: reset mid-debounce discards the partial count
    do_reset();
    pressed = 4'b0001;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("midrst_quiet", 32'(press_pulse), 0);
    end
    tick(1);
    chk("midrst_pulse", 32'(press_pulse), 'b0001);
    pressed = 4'b0000;
    tick(12);

    // Randomised buttons, steps and occasional resets against the model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          pressed[k] = ~pressed[k];
          hold[k]    = $urandom_range(1, 12);
        end
        hold[k]--;
      end
      step = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      tick(1);
      chk("rnd_dir",   32'(dir),         32'(m_dir()));
      chk("rnd_pulse", 32'(press_pulse), 32'(m_pulse));
      chk("rnd_count", 32'(queue_count), 32'(m_q.size()));
    end
    rst  = 1'b0;
    step = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
